event_monitor: RTL and testbench

EVENT_MONITOR -- requirements
Module: event_monitor

---
 rtl/event_monitor.sv | 136 +++++++++++++
 tb/tb_event_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_monitor.sv
// Event monitor: din rise detection, saturating event count, hold alarm
// FSM and a valid/ack snapshot port for the event count.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-low
//   din        registered input level from the upstream stage
//   clr        synchronous clear of event count and overflow
//   rd_req     single-cycle snapshot request
//   rd_ack     consumer acknowledge of rd_data
//   rd_valid   rd_data holds a snapshot
//   rd_data    snapshot event count
//   rise_pulse one-cycle pulse per din rising edge
//   hold_alarm din held high for at least HOLD_LEN cycles
//   overflow   sticky: a rise arrived with the counter saturated
module event_monitor #(
  parameter int CNT_W    = 8,
  parameter int HOLD_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clr,
  input  logic             rd_req,
  input  logic             rd_ack,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rise_pulse,
  output logic             hold_alarm,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [7:0]       HL  = 8'(HOLD_LEN);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    ALARM
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       run_q;
  logic [7:0]       run_d;
  logic             din_q;
  logic [CNT_W-1:0] event_cnt;
  logic             rise;

  assign rise = din & ~din_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (din) begin
          state_d = HIGH;
          run_d   = 8'd1;
        end
      end
      HIGH: begin
        if (!din) begin
          state_d = IDLE;
          run_d   = 8'd0;
        end else begin
          run_d = run_q + 8'd1;
          if (run_q + 8'd1 == HL)
            state_d = ALARM;
        end
      end
      ALARM: begin
        // run_cnt stays frozen while the alarm holds
        if (!din) begin
          state_d = IDLE;
          run_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_q      <= 8'd0;
      hold_alarm <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      hold_alarm <= (state_d == ALARM);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      din_q      <= 1'b0;
      rise_pulse <= 1'b0;
      event_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      din_q      <= din;
      rise_pulse <= rise;
      // clr beats a coincident rise; the pulse still fires
      if (clr) begin
        event_cnt <= '0;
        overflow  <= 1'b0;
      end else if (rise) begin
        if (event_cnt == MAX)
          overflow <= 1'b1;
        else
          event_cnt <= event_cnt + 1'b1;
      end
    end
  end

  // Snapshot takes the pre-edge count, so rd_req with clr
  // returns the count before the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (!rd_valid) begin
      if (rd_req) begin
        rd_valid <= 1'b1;
        rd_data  <= event_cnt;
      end
    end else if (rd_ack) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_monitor.sv
// Testbench for event_monitor: directed scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_event_monitor;

  localparam int CNT_W    = 8;
  localparam int HOLD_LEN = 4;
  localparam int MAXV     = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             din;
  logic             clr;
  logic             rd_req;
  logic             rd_ack;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rise_pulse;
  logic             hold_alarm;
  logic             overflow;

  event_monitor #(
    .CNT_W   (CNT_W),
    .HOLD_LEN(HOLD_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rise_pulse(rise_pulse),
    .hold_alarm(hold_alarm),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_cnt   = 0;
  int m_run   = 0;
  int m_data  = 0;
  bit m_prev  = 0;
  bit m_ovf   = 0;
  bit m_valid = 0;
  bit m_pulse = 0;
  bit m_alarm = 0;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit d,
                       input bit c, input bit q,
                       input bit a);
    bit rs;
    if (!r) begin
      m_cnt = 0; m_run = 0; m_data = 0;
      m_prev = 0; m_ovf = 0; m_valid = 0;
      m_pulse = 0; m_alarm = 0;
      return;
    end
    rs = d && !m_prev;
    m_prev  = d;
    m_pulse = rs;
    if (!m_valid) begin
      if (q) begin
        m_valid = 1;
        m_data  = m_cnt;
      end
    end else if (a) begin
      m_valid = 0;
    end
    if (c) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (rs) begin
      if (m_cnt == MAXV) m_ovf = 1;
      else m_cnt = m_cnt + 1;
    end
    m_run   = d ? m_run + 1 : 0;
    if (m_run > 1000) m_run = 1000;
    m_alarm = (m_run >= HOLD_LEN);
  endtask

  task automatic step(input bit r, input bit d,
                      input bit c = 0, input bit q = 0,
                      input bit a = 0);
    reset = r; din = d; clr = c;
    rd_req = q; rd_ack = a;
    @(posedge clk);
    model(r, d, c, q, a);
    #1;
    chk("rise_pulse", int'(rise_pulse), int'(m_pulse));
    chk("hold_alarm", int'(hold_alarm), int'(m_alarm));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rd_valid", int'(rd_valid), int'(m_valid));
    if (m_valid || !r)
      chk("rd_data", int'(rd_data), m_data);
  endtask

  task automatic pulse();
    step(1, 1);
    step(1, 0);
  endtask

  task automatic snap_ack();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 0; din = 0; clr = 0;
    rd_req = 0; rd_ack = 0;
    step(0, 0);
    step(0, 1, 1, 1, 1);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_alarm", int'(hold_alarm), 0);

    // three isolated pulses, then a snapshot
    step(1, 0);
    repeat (3) begin
      pulse();
      step(1, 0);
    end
    step(1, 0, 0, 1, 0);
    chk("snap3_valid", int'(rd_valid), 1);
    chk("snap3_data", int'(rd_data), 3);
    step(1, 0, 0, 0, 1);

    // 6 highs then low: alarm from the 4th high
    step(1, 0, 1);
    repeat (3) step(1, 1);
    chk("pre_alarm", int'(hold_alarm), 0);
    step(1, 1);
    chk("alarm_on", int'(hold_alarm), 1);
    repeat (2) step(1, 1);
    step(1, 0);
    chk("alarm_off", int'(hold_alarm), 0);
    step(1, 0, 0, 1, 0);
    chk("hold_cnt", int'(rd_data), 1);
    step(1, 0, 0, 0, 1);

    // 3 high, 1 low, 4 high
    step(1, 0, 1);
    repeat (3) step(1, 1);
    step(1, 0);
    repeat (4) step(1, 1);
    chk("burst2_alarm", int'(hold_alarm), 1);
    step(1, 0, 0, 1, 0);
    chk("burst_cnt", int'(rd_data), 2);
    step(1, 0, 0, 0, 1);

    // saturation and overflow
    step(1, 0, 1);
    repeat (257) pulse();
    chk("sat_ovf", int'(overflow), 1);
    step(1, 0, 0, 1, 0);
    chk("sat_data", int'(rd_data), MAXV);
    step(1, 0, 1, 0, 1);
    chk("clr_ovf", int'(overflow), 0);
    step(1, 1, 1);
    chk("clr_rise_pulse", int'(rise_pulse), 1);
    step(1, 0);
    snap_ack();
    chk("clr_rise_cnt", int'(rd_data), 0);

    // held snapshot ignores new requests
    step(1, 0, 1);
    repeat (5) pulse();
    step(1, 0, 0, 1, 0);
    step(1, 1);
    step(1, 0, 0, 1, 0);
    step(1, 1);
    step(1, 0);
    chk("hold_data", int'(rd_data), 5);
    chk("hold_valid", int'(rd_valid), 1);
    step(1, 0, 0, 0, 1);
    chk("ack_valid", int'(rd_valid), 0);
    step(1, 0, 0, 1, 0);
    chk("resnap_data", int'(rd_data), 7);
    step(1, 0, 0, 0, 1);

    // reset mid-alarm and mid-handshake
    step(1, 0, 1);
    repeat (8) pulse();
    repeat (4) step(1, 1);
    step(1, 1, 0, 1, 0);
    chk("pre_rst_alarm", int'(hold_alarm), 1);
    chk("pre_rst_data", int'(rd_data), 9);
    step(0, 1);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_alarm", int'(hold_alarm), 0);
    step(1, 1);
    chk("post_rst_rise", int'(rise_pulse), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, d, c, q, a;
      r = ($urandom_range(0, 199) != 0);
      d = (i % 16 < 8) ? ($urandom_range(0, 5) != 0)
                       : ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 63) == 0);
      q = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) == 0);
      step(r, d, c, q, a);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
